// File: rtl/alu_pkg.sv
// Shared constants and enumerations for the sequential ALU and its multiplier.
package alu_pkg;
    localparam int WIDTH     = 8;
    localparam int MUL_ITERS = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_e;
endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier: one partial product per step, MUL_ITERS steps per product.
module mul_shift_add
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [3:0]         count_q;

    // product is the value this step produces, so the caller can register it on the final edge
    assign product = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign last    = step && (count_q == 4'(MUL_ITERS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else if (load) begin
            prod_q   <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, mcand};
            mplier_q <= mplier;
            count_q  <= '0;
        end else if (step) begin
            prod_q   <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 4'd1;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU feeding the accumulator: single-cycle ops via EXEC, MUL via shift-add.
module alu_seq #(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             acc_we,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry
);
    import alu_pkg::*;

    state_e             state;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH:0]     ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               mul_load;
    logic               mul_step;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_product;

    assign mul_load = (state == S_IDLE) && start && (op_e'(op) == OP_MUL);
    assign mul_step = (state == S_MUL);
    assign acc_we   = done;

    mul_shift_add u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (mul_load),
        .step    (mul_step),
        .mcand   (a),
        .mplier  (b),
        .product (mul_product),
        .last    (mul_last)
    );

    always_comb begin
        ext     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD: begin
                ext     = {1'b0, a_q} + {1'b0, b_q};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_SUB: begin
                // bit WIDTH of the widened difference is the borrow (a < b)
                ext     = {1'b0, a_q} - {1'b0, b_q};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res = {a_q[WIDTH-2:0], 1'b0};
                alu_c   = a_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[WIDTH-1:1]};
                alu_c   = a_q[0];
            end
            default: ;
        endcase
    end

    // done is registered out of DONE, so it is seen in the following IDLE cycle;
    // busy is held through that cycle so it covers the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
            carry  <= 1'b0;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op_e'(op);
                        a_q   <= a;
                        b_q   <= b;
                        busy  <= 1'b1;
                        state <= (op_e'(op) == OP_MUL) ? S_MUL : S_EXEC;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_EXEC: begin
                    result <= alu_res;
                    zero   <= (alu_res == '0);
                    carry  <= alu_c;
                    state  <= S_DONE;
                end
                S_MUL: begin
                    if (mul_last) begin
                        result <= mul_product[WIDTH-1:0];
                        zero   <= (mul_product[WIDTH-1:0] == '0);
                        carry  <= |mul_product[2*WIDTH-1:WIDTH];
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with a behavioural ALU model and a negedge accumulator model.
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [2:0] op_i;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       busy;
    logic       done;
    logic       acc_we;
    logic [7:0] result;
    logic       zero;
    logic       carry;

    int n_checks = 0;
    int n_pass   = 0;
    int cap_n    = 0;
    logic [7:0] cap_last = 8'h00;

    alu_seq #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op_i),
        .a       (a_i),
        .b       (b_i),
        .busy    (busy),
        .done    (done),
        .acc_we  (acc_we),
        .result  (result),
        .zero    (zero),
        .carry   (carry)
    );

    always #5 clk = ~clk;

    // Accumulator model: captures result on negedge while enable is high.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && acc_we === 1'b1) begin
            cap_n    = cap_n + 1;
            cap_last = result;
        end
    end

    function automatic void model(input int opc, input int x, input int y,
                                  output int r, output int c);
        int t;
        t = 0;
        c = 0;
        case (opc)
            0: begin t = x + y; c = (t > 255) ? 1 : 0; end
            1: begin t = x - y; c = (x < y) ? 1 : 0; end
            2: t = x & y;
            3: t = x | y;
            4: t = x ^ y;
            5: begin t = x * 2; c = (x >= 128) ? 1 : 0; end
            6: begin t = x / 2; c = x % 2; end
            default: begin t = x * y; c = (t > 255) ? 1 : 0; end
        endcase
        r = t & 255;
    endfunction

    // Issues one request and follows it until one cycle past done.
    task automatic run_op(input int opc, input int x, input int y,
                          output logic [7:0] r, output logic c, output logic z,
                          output int lat, output int caps, output logic [7:0] capv,
                          output logic we_at_done, output logic busy_at_done,
                          output logic done_after);
        int c0;
        c0 = cap_n;
        @(negedge clk);
        start = 1'b1;
        op_i  = 3'(opc);
        a_i   = 8'(x);
        b_i   = 8'(y);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_i  = 3'($urandom);
        a_i   = 8'($urandom);
        b_i   = 8'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r            = result;
        c            = carry;
        z            = zero;
        we_at_done   = acc_we;
        busy_at_done = busy;
        @(negedge clk);
        #1;
        caps = cap_n - c0;
        capv = cap_last;
        @(posedge clk);
        #1;
        done_after = done;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        op_i    = 3'd0;
        a_i     = 8'h00;
        b_i     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0 || acc_we !== 1'b0) $display("FAIL reset_done got %b/%b want 0/0", done, acc_we); else n_pass++;
        n_checks++; if (result !== 8'h00) $display("FAIL reset_result got %02h want 00", result); else n_pass++;
        n_checks++; if (zero !== 1'b1 || carry !== 1'b0) $display("FAIL reset_flags got z%b c%b want z1 c0", zero, carry); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_after_reset got busy%b done%b want 0/0", busy, done); else n_pass++;
    endtask

    task automatic test_add_sub();
        int ops[3] = '{0, 1, 1};
        int xs[3]  = '{8'hF0, 8'h05, 8'h03};
        int ys[3]  = '{8'h20, 8'h05, 8'h07};
        logic [7:0] er[3] = '{8'h10, 8'h00, 8'hFC};
        logic ec[3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0] r, capv;
        logic c, z, we, bz, da;
        int lat, caps;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], xs[i], ys[i], r, c, z, lat, caps, capv, we, bz, da);
            n_checks++; if (r !== er[i]) $display("FAIL addsub%0d_result got %02h want %02h", i, r, er[i]); else n_pass++;
            n_checks++; if (c !== ec[i]) $display("FAIL addsub%0d_carry got %b want %b", i, c, ec[i]); else n_pass++;
            n_checks++; if (z !== (er[i] == 8'h00)) $display("FAIL addsub%0d_zero got %b want %b", i, z, er[i] == 8'h00); else n_pass++;
            n_checks++; if (lat != 2) $display("FAIL addsub%0d_latency got %0d want 2", i, lat); else n_pass++;
            n_checks++; if (we !== 1'b1 || bz !== 1'b1) $display("FAIL addsub%0d_we_busy got %b/%b want 1/1", i, we, bz); else n_pass++;
            n_checks++; if (da !== 1'b0) $display("FAIL addsub%0d_done_width got %b want 0", i, da); else n_pass++;
            n_checks++; if (caps != 1 || capv !== er[i]) $display("FAIL addsub%0d_capture got %0d x %02h want 1 x %02h", i, caps, capv, er[i]); else n_pass++;
        end
    endtask

    task automatic test_mul();
        int xs[3] = '{8'h0F, 8'h20, 8'hFF};
        int ys[3] = '{8'h11, 8'h10, 8'hFF};
        logic [7:0] er[3] = '{8'hFF, 8'h00, 8'h01};
        logic ec[3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] r, capv;
        logic c, z, we, bz, da;
        int lat, caps;
        for (int i = 0; i < 3; i++) begin
            run_op(7, xs[i], ys[i], r, c, z, lat, caps, capv, we, bz, da);
            n_checks++; if (r !== er[i]) $display("FAIL mul%0d_result got %02h want %02h", i, r, er[i]); else n_pass++;
            n_checks++; if (c !== ec[i]) $display("FAIL mul%0d_carry got %b want %b", i, c, ec[i]); else n_pass++;
            n_checks++; if (z !== (er[i] == 8'h00)) $display("FAIL mul%0d_zero got %b want %b", i, z, er[i] == 8'h00); else n_pass++;
            n_checks++; if (lat != 9) $display("FAIL mul%0d_latency got %0d want 9", i, lat); else n_pass++;
            n_checks++; if (caps != 1 || capv !== er[i]) $display("FAIL mul%0d_capture got %0d x %02h want 1 x %02h", i, caps, capv, er[i]); else n_pass++;
        end
    endtask

    task automatic test_logic_shift();
        int ops[4] = '{6, 2, 3, 4};
        int xs[4]  = '{8'h01, 8'hAA, 8'hAA, 8'hAA};
        int ys[4]  = '{8'h00, 8'h0F, 8'h0F, 8'h0F};
        logic [7:0] er[4] = '{8'h00, 8'h0A, 8'hAF, 8'hA5};
        logic ec[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] r, capv;
        logic c, z, we, bz, da;
        int lat, caps;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], xs[i], ys[i], r, c, z, lat, caps, capv, we, bz, da);
            n_checks++; if (r !== er[i]) $display("FAIL logic%0d_result got %02h want %02h", i, r, er[i]); else n_pass++;
            n_checks++; if (c !== ec[i] || z !== (er[i] == 8'h00)) $display("FAIL logic%0d_flags got c%b z%b want c%b z%b", i, c, z, ec[i], er[i] == 8'h00); else n_pass++;
            n_checks++; if (caps != 1 || capv !== er[i]) $display("FAIL logic%0d_capture got %0d x %02h want 1 x %02h", i, caps, capv, er[i]); else n_pass++;
        end
    endtask

    task automatic test_ignore_start();
        int c0, done_cnt, done_at;
        c0 = cap_n;
        done_cnt = 0;
        done_at = -1;
        @(negedge clk);
        start = 1'b1; op_i = 3'd7; a_i = 8'h0F; b_i = 8'h11;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = (k == 3 || k == 5);
            op_i = 3'd0; a_i = 8'h01; b_i = 8'h01;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
        end
        n_checks++; if (done_cnt != 1 || done_at != 9) $display("FAIL ignore_done got %0d pulses last at %0d want 1 at 9", done_cnt, done_at); else n_pass++;
        n_checks++; if (result !== 8'hFF) $display("FAIL ignore_result got %02h want ff", result); else n_pass++;
        n_checks++; if (cap_n - c0 != 1 || cap_last !== 8'hFF) $display("FAIL ignore_capture got %0d x %02h want 1 x ff", cap_n - c0, cap_last); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL ignore_idle_busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int c0;
        logic [7:0] r, capv;
        logic c, z, we, bz, da;
        int lat, caps;
        c0 = cap_n;
        @(negedge clk);
        start = 1'b1; op_i = 3'd7; a_i = 8'h37; b_i = 8'h5B;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        n_checks++; if (busy !== 1'b1) $display("FAIL abort_busy_before got %b want 1", busy); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_busy got %b done %b want 0/0", busy, done); else n_pass++;
        n_checks++; if (result !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) $display("FAIL abort_result got %02h z%b c%b want 00 z1 c0", result, zero, carry); else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_checks++; if (cap_n != c0 || busy !== 1'b0) $display("FAIL abort_no_done got %0d captures busy %b want 0/0", cap_n - c0, busy); else n_pass++;
        run_op(5, 8'h81, 8'h00, r, c, z, lat, caps, capv, we, bz, da);
        n_checks++; if (r !== 8'h02 || c !== 1'b1 || z !== 1'b0) $display("FAIL post_abort_shl got %02h c%b z%b want 02 c1 z0", r, c, z); else n_pass++;
        n_checks++; if (lat != 2 || caps != 1) $display("FAIL post_abort_timing got lat %0d caps %0d want 2/1", lat, caps); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int c0;
        logic exp_done;
        c0 = cap_n;
        @(negedge clk);
        start = 1'b1; op_i = 3'd0; a_i = 8'h03; b_i = 8'h04;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 11) start = 1'b0;
            exp_done = (k % 3 == 2);
            n_checks++; if (done !== exp_done || busy !== 1'b1) $display("FAIL b2b_cycle%0d got done%b busy%b want done%b busy1", k, done, busy, exp_done); else n_pass++;
        end
        @(negedge clk);
        #1;
        n_checks++; if (cap_n - c0 != 4 || cap_last !== 8'h07) $display("FAIL b2b_captures got %0d x %02h want 4 x 07", cap_n - c0, cap_last); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_drain got busy%b done%b want 0/0", busy, done); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] r, capv;
        logic c, z, we, bz, da;
        int lat, caps, opc, x, y, er, ec;
        for (int i = 0; i < 40; i++) begin
            opc = int'($urandom_range(0, 7));
            x   = int'($urandom_range(0, 255));
            y   = int'($urandom_range(0, 255));
            model(opc, x, y, er, ec);
            run_op(opc, x, y, r, c, z, lat, caps, capv, we, bz, da);
            n_checks++;
            if (r !== 8'(er) || c !== 1'(ec) || z !== (er == 0) || lat != ((opc == 7) ? 9 : 2) || caps != 1)
                $display("FAIL rand%0d op%0d %02h,%02h got %02h c%b z%b lat%0d caps%0d want %02h c%0d z%0d lat%0d caps1",
                         i, opc, x, y, r, c, z, lat, caps, er, ec, er == 0, (opc == 7) ? 9 : 2);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_logic_shift();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
